h264_drain: RTL and testbench

H264_DRAIN -- requirements
Module: h264_drain

---
 rtl/h264_drain.sv | 116 +++++++++++
 tb/tb_h264_drain.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/h264_drain.sv
// rtl/h264_drain.sv - drains the H.264 encoder output buffer onto a valid/ready word stream
// Optional H264_DRAIN_CNT_EN macro enables the delivered-word counter on words_total.
module h264_drain (
   input  logic        clk,
   input  logic        rst,
   input  logic        h264_reset,
   input  logic        drain_en,
   input  logic [7:0]  drain_threshold,
   input  logic        flush,
   input  logic [31:0] h264_buf_cnt,
   input  logic [31:0] h264_out,
   output logic [7:0]  h264_addr,
   output logic        h264_buf_clear,
   output logic        enc_hold,
   output logic        m_valid,
   output logic [31:0] m_data,
   output logic        m_last,
   input  logic        m_ready,
   output logic        busy,
   output logic [31:0] words_total
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] SETTLE = 3'd1;
   localparam logic [2:0] READ   = 3'd2;
   localparam logic [2:0] WAIT   = 3'd3;
   localparam logic [2:0] SEND   = 3'd4;
   localparam logic [2:0] CLEAR  = 3'd5;

   logic [2:0] state;
   logic [1:0] settle_cnt;
   logic [8:0] ptr;
   logic [8:0] n_words;
   logic       flush_pend;
   logic       soft_clr;
   logic [7:0] thr_eff;
   logic       trigger;
   logic [8:0] ptr_inc;
   logic       last_hs;

   assign soft_clr = rst | h264_reset;
   // A zero threshold would fire on an empty buffer, so treat it as one.
   assign thr_eff  = (drain_threshold == 8'd0) ? 8'd1 : drain_threshold;
   assign trigger  = drain_en &&
                     ((h264_buf_cnt >= {24'd0, thr_eff}) ||
                      (flush_pend && (h264_buf_cnt != 32'd0)));
   assign ptr_inc  = ptr + 9'd1;
   assign last_hs  = (state == SEND) && m_ready && !(ptr_inc < n_words);

   always_ff @(posedge clk) begin
      if (soft_clr) begin
         state      <= IDLE;
         settle_cnt <= 2'd0;
         ptr        <= 9'd0;
         n_words    <= 9'd0;
         m_data     <= 32'd0;
         flush_pend <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (trigger) begin
                  state      <= SETTLE;
                  settle_cnt <= 2'd0;
               end
            end
            SETTLE: begin
               settle_cnt <= settle_cnt + 2'd1;
               if (settle_cnt == 2'd3) begin
                  n_words <= (h264_buf_cnt > 32'd256) ? 9'd256 : h264_buf_cnt[8:0];
                  ptr     <= 9'd0;
                  state   <= READ;
               end
            end
            READ:  state <= WAIT;
            WAIT: begin
               m_data <= h264_out;
               state  <= SEND;
            end
            SEND: begin
               if (m_ready) begin
                  ptr   <= ptr_inc;
                  state <= (ptr_inc < n_words) ? READ : CLEAR;
               end
            end
            CLEAR:   state <= IDLE;
            default: state <= IDLE;
         endcase

         // A flush landing on the final handshake survives, so leftover words drain next.
         if (flush)
            flush_pend <= 1'b1;
         else if (last_hs || ((state == IDLE) && (h264_buf_cnt == 32'd0)))
            flush_pend <= 1'b0;
      end
   end

   assign h264_addr      = ptr[7:0];
   assign h264_buf_clear = (state == CLEAR);
   assign enc_hold       = (state != IDLE);
   assign busy           = (state != IDLE);
   assign m_valid        = (state == SEND);
   assign m_last         = (state == SEND) && (ptr == n_words - 9'd1);

`ifdef H264_DRAIN_CNT_EN
   // Only the hard reset clears the running total; the soft reset leaves it alone.
   always_ff @(posedge clk) begin
      if (rst)
         words_total <= 32'd0;
      else if (m_valid && m_ready)
         words_total <= words_total + 32'd1;
   end
`else
   assign words_total = 32'd0;
`endif

endmodule

// File: tb/tb_h264_drain.sv
// tb/tb_h264_drain.sv - self-checking bench for h264_drain with a buffer model and word scoreboard
module tb_h264_drain;

`ifdef H264_DRAIN_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        h264_reset = 1'b0;
   logic        drain_en = 1'b0;
   logic [7:0]  drain_threshold = 8'd0;
   logic        flush = 1'b0;
   logic [31:0] h264_buf_cnt = 32'd0;
   logic [31:0] h264_out = 32'd0;
   logic [7:0]  h264_addr;
   logic        h264_buf_clear;
   logic        enc_hold;
   logic        m_valid;
   logic [31:0] m_data;
   logic        m_last;
   logic        m_ready = 1'b1;
   logic        busy;
   logic [31:0] words_total;

   logic [31:0] mem [0:255];
   int          n_chk = 0;
   int          n_pass = 0;
   int          cyc = 0;
   int          exp_total = 0;
   int          clr_cnt = 0;
   int          hold_cnt = 0;
   int          busy_cnt = 0;
   int          valid_cnt = 0;
   logic [31:0] q_data [$];
   bit          q_last [$];
   int          q_cyc [$];

   h264_drain dut (
      .clk(clk), .rst(rst), .h264_reset(h264_reset), .drain_en(drain_en),
      .drain_threshold(drain_threshold), .flush(flush), .h264_buf_cnt(h264_buf_cnt),
      .h264_out(h264_out), .h264_addr(h264_addr), .h264_buf_clear(h264_buf_clear),
      .enc_hold(enc_hold), .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
      .m_ready(m_ready), .busy(busy), .words_total(words_total)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      h264_out <= mem[h264_addr];
   end

   always @(negedge clk) begin
      if (m_valid && m_ready) begin
         q_data.push_back(m_data);
         q_last.push_back(m_last);
         q_cyc.push_back(cyc);
      end
      if (h264_buf_clear) clr_cnt <= clr_cnt + 1;
      if (enc_hold)       hold_cnt <= hold_cnt + 1;
      if (busy)           busy_cnt <= busy_cnt + 1;
      if (m_valid)        valid_cnt <= valid_cnt + 1;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic fill_mem(input int n);
      for (int i = 0; i < n; i++) mem[i] = ($urandom & 32'hFFFF_FF00) | 32'(i);
   endtask

   task automatic do_reset;
      rst = 1'b1; h264_reset = 1'b0; drain_en = 1'b0; flush = 1'b0;
      h264_buf_cnt = 32'd0; m_ready = 1'b1;
      tick; tick;
      rst = 1'b0;
      exp_total = 0;
      tick;
   endtask

   // Runs until the clear pulse, then the integrator refills the buffer count to 'remain'.
   task automatic wait_drain(input bit rnd, input int budget, input int remain, output bit done);
      done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         if (rnd) m_ready = ($urandom_range(0, 3) != 0);
         tick;
         if (h264_buf_clear) begin
            done = 1'b1;
            h264_buf_cnt = 32'(remain);
         end
      end
      m_ready = 1'b1;
      tick; tick;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick;
      n_chk++;
      if ({h264_addr, h264_buf_clear, enc_hold, m_valid, m_data, m_last, busy} !== 46'd0)
         $display("FAIL reset_outputs got addr=%0h clr=%b hold=%b v=%b d=%h l=%b busy=%b want all 0",
                  h264_addr, h264_buf_clear, enc_hold, m_valid, m_data, m_last, busy);
      else n_pass++;
      n_chk++;
      if (words_total !== 32'd0) $display("FAIL reset_words_total got %0d want 0", words_total);
      else n_pass++;
      do_reset;
   endtask

   task automatic test_threshold;
      bit done;
      int qb, cb, hb, c0;
      do_reset;
      fill_mem(4);
      drain_en = 1'b1; drain_threshold = 8'd4;
      qb = q_data.size(); cb = clr_cnt; hb = hold_cnt; c0 = cyc;
      h264_buf_cnt = 32'd4;
      tick;
      n_chk++;
      if (enc_hold !== 1'b1) $display("FAIL thr_hold_rise got %b want 1", enc_hold);
      else n_pass++;
      wait_drain(1'b0, 60, 0, done);
      n_chk++;
      if (!done) $display("FAIL thr_timeout got no clear want clear");
      else n_pass++;
      exp_total += 4;
      n_chk++;
      if (q_data.size() - qb !== 4) $display("FAIL thr_count got %0d want 4", q_data.size() - qb);
      else n_pass++;
      for (int k = 0; k < 4 && qb + k < q_data.size(); k++) begin
         n_chk++;
         if (q_data[qb+k] !== mem[k] || q_last[qb+k] !== (k == 3) || q_cyc[qb+k] !== c0 + 7 + 3*k)
            $display("FAIL thr_word%0d got d=%h l=%b c=%0d want d=%h l=%b c=%0d", k,
                     q_data[qb+k], q_last[qb+k], q_cyc[qb+k], mem[k], k == 3, c0 + 7 + 3*k);
         else n_pass++;
      end
      n_chk++;
      if (clr_cnt - cb !== 1) $display("FAIL thr_clear got %0d want 1", clr_cnt - cb);
      else n_pass++;
      n_chk++;
      if (hold_cnt - hb !== 17) $display("FAIL thr_hold_len got %0d want 17", hold_cnt - hb);
      else n_pass++;
      n_chk++;
      if (words_total !== 32'(CNT_EN ? exp_total : 0))
         $display("FAIL thr_words_total got %0d want %0d", words_total, CNT_EN ? exp_total : 0);
      else n_pass++;
   endtask

   task automatic test_flush;
      bit done;
      int qb, cb, bb;
      do_reset;
      fill_mem(3);
      drain_en = 1'b1; drain_threshold = 8'd16;
      h264_buf_cnt = 32'd3;
      bb = busy_cnt;
      repeat (6) tick;
      n_chk++;
      if (busy_cnt !== bb) $display("FAIL flush_below_thr got %0d busy cycles want 0", busy_cnt - bb);
      else n_pass++;
      qb = q_data.size(); cb = clr_cnt;
      flush = 1'b1; tick; flush = 1'b0;
      wait_drain(1'b0, 60, 0, done);
      exp_total += 3;
      n_chk++;
      if (!done || q_data.size() - qb !== 3)
         $display("FAIL flush_count got %0d done=%b want 3", q_data.size() - qb, done);
      else n_pass++;
      for (int k = 0; k < 3 && qb + k < q_data.size(); k++) begin
         n_chk++;
         if (q_data[qb+k] !== mem[k] || q_last[qb+k] !== (k == 2))
            $display("FAIL flush_word%0d got d=%h l=%b want d=%h l=%b", k,
                     q_data[qb+k], q_last[qb+k], mem[k], k == 2);
         else n_pass++;
      end
      n_chk++;
      if (clr_cnt - cb !== 1) $display("FAIL flush_clear got %0d want 1", clr_cnt - cb);
      else n_pass++;
      bb = busy_cnt;
      flush = 1'b1; tick; flush = 1'b0;
      repeat (5) tick;
      h264_buf_cnt = 32'd3;
      repeat (8) tick;
      n_chk++;
      if (busy_cnt !== bb) $display("FAIL flush_empty_pend got %0d busy cycles want 0", busy_cnt - bb);
      else n_pass++;
      h264_buf_cnt = 32'd0;
      tick;
      n_chk++;
      if (words_total !== 32'(CNT_EN ? exp_total : 0))
         $display("FAIL flush_words_total got %0d want %0d", words_total, CNT_EN ? exp_total : 0);
      else n_pass++;
   endtask

   task automatic test_backpressure;
      bit done;
      int qb;
      logic [31:0] hd;
      logic [7:0]  ha;
      do_reset;
      fill_mem(6);
      drain_en = 1'b1; drain_threshold = 8'd4;
      qb = q_data.size();
      h264_buf_cnt = 32'd6;
      for (int i = 0; i < 40 && q_data.size() == qb; i++) tick;
      m_ready = 1'b0;
      for (int i = 0; i < 10 && !m_valid; i++) tick;
      hd = m_data; ha = h264_addr;
      n_chk++;
      if (m_valid !== 1'b1 || hd !== mem[1])
         $display("FAIL bp_word1 got v=%b d=%h want v=1 d=%h", m_valid, hd, mem[1]);
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         tick;
         n_chk++;
         if (m_valid !== 1'b1 || m_data !== mem[1] || h264_addr !== 8'd1)
            $display("FAIL bp_hold%0d got v=%b d=%h a=%0d want v=1 d=%h a=1", i,
                     m_valid, m_data, h264_addr, mem[1]);
         else n_pass++;
      end
      m_ready = 1'b1;
      wait_drain(1'b0, 60, 0, done);
      n_chk++;
      if (!done || q_data.size() - qb !== 6)
         $display("FAIL bp_count got %0d done=%b want 6", q_data.size() - qb, done);
      else n_pass++;
      for (int k = 0; k < 6 && qb + k < q_data.size(); k++) begin
         n_chk++;
         if (q_data[qb+k] !== mem[k]) $display("FAIL bp_word%0d got %h want %h", k, q_data[qb+k], mem[k]);
         else n_pass++;
      end
   endtask

   task automatic test_full_and_refill;
      bit done;
      int qb, cb, nl;
      do_reset;
      fill_mem(256);
      drain_en = 1'b1; drain_threshold = 8'($urandom_range(1, 44));
      qb = q_data.size(); cb = clr_cnt;
      h264_buf_cnt = 32'd300;
      wait_drain(1'b0, 900, 44, done);
      n_chk++;
      if (!done || q_data.size() - qb !== 256)
         $display("FAIL full_count got %0d done=%b want 256", q_data.size() - qb, done);
      else n_pass++;
      nl = 0;
      for (int k = 0; k < 256 && qb + k < q_data.size(); k++) begin
         n_chk++;
         if (q_data[qb+k] !== mem[k]) $display("FAIL full_word%0d got %h want %h", k, q_data[qb+k], mem[k]);
         else n_pass++;
         if (q_last[qb+k]) nl++;
      end
      n_chk++;
      if (nl !== 1 || q_last[qb+255] !== 1'b1) $display("FAIL full_last got %0d lasts want 1 at 255", nl);
      else n_pass++;
      n_chk++;
      if (clr_cnt - cb !== 1) $display("FAIL full_clear got %0d want 1", clr_cnt - cb);
      else n_pass++;
      qb = q_data.size();
      wait_drain(1'b0, 200, 0, done);
      n_chk++;
      if (!done || q_data.size() - qb !== 44)
         $display("FAIL refill_count got %0d done=%b want 44", q_data.size() - qb, done);
      else n_pass++;
      for (int k = 0; k < 44 && qb + k < q_data.size(); k++) begin
         n_chk++;
         if (q_data[qb+k] !== mem[k] || q_last[qb+k] !== (k == 43))
            $display("FAIL refill_word%0d got d=%h l=%b want d=%h l=%b", k,
                     q_data[qb+k], q_last[qb+k], mem[k], k == 43);
         else n_pass++;
      end
      exp_total += 300;
      n_chk++;
      if (words_total !== 32'(CNT_EN ? exp_total : 0))
         $display("FAIL full_words_total got %0d want %0d", words_total, CNT_EN ? exp_total : 0);
      else n_pass++;
   endtask

   task automatic test_soft_reset;
      int qb, cb, vb;
      do_reset;
      fill_mem(8);
      drain_en = 1'b1; drain_threshold = 8'd8;
      qb = q_data.size();
      h264_buf_cnt = 32'd8;
      for (int i = 0; i < 40 && q_data.size() == qb; i++) tick;
      m_ready = 1'b0;
      for (int i = 0; i < 10 && !m_valid; i++) tick;
      exp_total += 1;
      n_chk++;
      if (m_valid !== 1'b1 || m_data !== mem[1])
         $display("FAIL srst_pre got v=%b d=%h want v=1 d=%h", m_valid, m_data, mem[1]);
      else n_pass++;
      h264_reset = 1'b1; h264_buf_cnt = 32'd0;
      cb = clr_cnt;
      tick;
      n_chk++;
      if ({h264_addr, h264_buf_clear, enc_hold, m_valid, m_data, m_last, busy} !== 46'd0)
         $display("FAIL srst_outputs got addr=%0h clr=%b hold=%b v=%b d=%h l=%b busy=%b want all 0",
                  h264_addr, h264_buf_clear, enc_hold, m_valid, m_data, m_last, busy);
      else n_pass++;
      n_chk++;
      if (words_total !== 32'(CNT_EN ? exp_total : 0))
         $display("FAIL srst_words_total got %0d want %0d", words_total, CNT_EN ? exp_total : 0);
      else n_pass++;
      h264_reset = 1'b0; m_ready = 1'b1;
      vb = valid_cnt;
      repeat (10) tick;
      n_chk++;
      if (valid_cnt !== vb || clr_cnt !== cb)
         $display("FAIL srst_quiet got valid=%0d clear=%0d want 0 0", valid_cnt - vb, clr_cnt - cb);
      else n_pass++;
   endtask

   task automatic test_cnt_change;
      bit done;
      int qb, cb;
      do_reset;
      fill_mem(6);
      drain_en = 1'b0; drain_threshold = 8'd4;
      h264_buf_cnt = 32'd4;
      repeat (4) tick;
      n_chk++;
      if (busy !== 1'b0) $display("FAIL cc_disabled got busy=%b want 0", busy);
      else n_pass++;
      qb = q_data.size(); cb = clr_cnt;
      drain_en = 1'b1;
      repeat (5) tick;
      drain_en = 1'b0;
      h264_buf_cnt = 32'd6;
      wait_drain(1'b0, 60, 0, done);
      n_chk++;
      if (!done || q_data.size() - qb !== 4)
         $display("FAIL cc_count got %0d done=%b want 4", q_data.size() - qb, done);
      else n_pass++;
      for (int k = 0; k < 4 && qb + k < q_data.size(); k++) begin
         n_chk++;
         if (q_data[qb+k] !== mem[k] || q_last[qb+k] !== (k == 3))
            $display("FAIL cc_word%0d got d=%h l=%b want d=%h l=%b", k,
                     q_data[qb+k], q_last[qb+k], mem[k], k == 3);
         else n_pass++;
      end
      n_chk++;
      if (clr_cnt - cb !== 1) $display("FAIL cc_clear got %0d want 1", clr_cnt - cb);
      else n_pass++;
   endtask

   task automatic test_random;
      bit done;
      int qb, cb, thr, cnt;
      do_reset;
      drain_en = 1'b1;
      for (int it = 0; it < 8; it++) begin
         thr = $urandom_range(0, 20);
         cnt = $urandom_range(1, 40);
         fill_mem(40);
         drain_threshold = 8'(thr);
         qb = q_data.size(); cb = clr_cnt;
         h264_buf_cnt = 32'(cnt);
         if (cnt < ((thr == 0) ? 1 : thr)) begin
            flush = 1'b1; tick; flush = 1'b0;
         end
         wait_drain(1'b1, 600, 0, done);
         exp_total += cnt;
         n_chk++;
         if (!done || q_data.size() - qb !== cnt || clr_cnt - cb !== 1)
            $display("FAIL rnd%0d_count got %0d clear=%0d want %0d clear=1", it,
                     q_data.size() - qb, clr_cnt - cb, cnt);
         else n_pass++;
         for (int k = 0; k < cnt && qb + k < q_data.size(); k++) begin
            n_chk++;
            if (q_data[qb+k] !== mem[k] || q_last[qb+k] !== (k == cnt - 1))
               $display("FAIL rnd%0d_word%0d got d=%h l=%b want d=%h l=%b", it, k,
                        q_data[qb+k], q_last[qb+k], mem[k], k == cnt - 1);
            else n_pass++;
         end
      end
      n_chk++;
      if (words_total !== 32'(CNT_EN ? exp_total : 0))
         $display("FAIL rnd_words_total got %0d want %0d", words_total, CNT_EN ? exp_total : 0);
      else n_pass++;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'd0;
      test_reset;
      test_threshold;
      test_flush;
      test_backpressure;
      test_full_and_refill;
      test_soft_reset;
      test_cnt_change;
      test_random;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout got no finish want finish");
      $fatal(1);
   end

endmodule
